inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Write-side companion of the CPU instruction memory: receives a program as a byte stream and writes it as 32-bit words into a writable instruction RAM, starting at word 0.
- Holds the CPU in reset until the load is complete.
- The RAM's read side indexes words by byte address bits [ADDR_W+1:2], so this block emits byte addresses (word index << 2).

Parameters:
- ADDR_W, 5, word-index width; RAM depth is 2**ADDR_W words (32 by default).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load. Sampled only in IDLE or DONE.
- len_words  input  ADDR_W+1  number of words to load; sampled on the start cycle.
- in_valid  input  1  in_byte is valid this cycle.
- in_byte  input  8  program byte; the first byte of each word is bits [31:24] (big-endian).
- in_ready  output  1  loader accepts in_byte this cycle.
- wr_en  output  1  one-cycle RAM write strobe.
- wr_addr  output  32  byte address of the word being written; always a multiple of 4.
- wr_data  output  32  assembled word.
- busy  output  1  load in progress.
- done  output  1  load finished successfully; level, held until the next start.
- err  output  1  sticky error flag; cleared by the next accepted start.
- cpu_hold  output  1  drives the CPU reset; high from reset until a successful load.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
  - Byte counter, word counter and shift register are cleared.
  - Reset mid-load discards any partial word; RAM contents already written are unspecified to the CPU.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE with start=1:
  - len_words=0: go to DONE; done=1, cpu_hold=0; no writes.
  - len_words > 2**ADDR_W: err=1; stay in or return to IDLE; done=0, cpu_hold=1.
  - Otherwise: go to RECV; busy=1, done=0, err=0, cpu_hold=1; word counter=0, byte counter=0.
- RECV:
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready: shift register = {shift[23:0], in_byte}; byte counter increments.
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, wr_en=1, wr_data=assembled word, wr_addr={word_cnt,2'b00} zero-extended to 32 bits.
  - Increment word_cnt.
  - If word_cnt+1 == len_words: go to DONE (busy=0, done=1, cpu_hold=0). Else return to RECV.
- Throughput: at most 4 bytes per 5 cycles; the first wr_en occurs 1 cycle after the 4th byte handshake.
- start while in RECV or WRITE is ignored.
- in_valid while in IDLE or DONE is ignored (in_ready=0).
- wr_addr and wr_data hold their last value when wr_en=0.
- len_words == 2**ADDR_W: the last word goes to index 2**ADDR_W-1. The word counter never wraps.

Optional Feature:
- Macro INST_LOADER_CSUM_EN.
- When defined:
  - After the last word's WRITE, the block enters state CSUM (in_ready=1) instead of DONE and accepts one extra byte.
  - If that byte equals the 8-bit modulo-256 sum of all program bytes: go to DONE as normal.
  - Otherwise: err=1, done=0, cpu_hold stays 1, return to IDLE.
  - len_words=0 still goes directly to DONE with no checksum byte.
- When undefined: no CSUM state and no sum register; the block goes straight to DONE after the last write.

Test Plan:
- Reset then idle: after rst_n release, cpu_hold=1, done=0, in_ready=0, wr_en=0; these hold for 10 cycles with no start.
- Single word: start, len_words=1; bytes 00 00 28 20 with in_valid held high -> one wr_en with wr_addr=0x0, wr_data=0x00002820; next cycle done=1, cpu_hold=0, busy=0.
- Three words with a gapped stream (in_valid toggling every other cycle): words 8CB10000, 8CB20004, 02329822 -> wr_addr sequence 0x0, 0x4, 0x8 with matching data; in_ready=0 in each WRITE cycle.
- Bounds: len_words=33 -> err=1, no wr_en, cpu_hold=1. Then len_words=0 -> err=0, done=1, cpu_hold=0, no wr_en.
- Reset mid-load: assert rst_n=0 after 2 bytes of the second word -> all outputs return to reset values immediately. A subsequent one-word load writes address 0x0 correctly.
- With INST_LOADER_CSUM_EN: word 00002820 followed by checksum 0x48 -> done=1. Repeating with checksum 0x47 -> err=1, done=0, cpu_hold=1.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: receives a program as a big-endian byte stream and writes it
// as 32-bit words into the instruction RAM, starting at word 0. The CPU is
// held in reset until the load completes.
// Optional feature: define INST_LOADER_CSUM_EN to require a trailing byte
// after the last word, equal to the modulo-256 sum of all program bytes.
module inst_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

`ifdef INST_LOADER_CSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  // RAM depth in words; len_words above this is rejected
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic [ADDR_W:0]  len_q;
  logic [ADDR_W:0]  word_cnt_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      shift_q;
  logic             in_ready_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             cpu_hold_q;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]       csum_q;
`endif

  logic [31:0]      shift_d;
  logic [ADDR_W:0]  word_cnt_d;
  logic             accept;

  // Next-value helpers shared by the FSM
  assign shift_d    = {shift_q[23:0], in_byte};
  assign word_cnt_d = word_cnt_q + ONE;
  assign accept     = in_valid && in_ready_q;

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

  // Load FSM with registered outputs; the word counter is one bit wider than
  // the RAM index so a full-depth load never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef INST_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (len_words == '0) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b0;
              cpu_hold_q <= 1'b0;
            end else if (len_words > DEPTH) begin
              state_q    <= IDLE;
              err_q      <= 1'b1;
              done_q     <= 1'b0;
              cpu_hold_q <= 1'b1;
            end else begin
              state_q    <= RECV;
              len_q      <= len_words;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              cpu_hold_q <= 1'b1;
`ifdef INST_LOADER_CSUM_EN
              csum_q     <= '0;
`endif
            end
          end
        end
        RECV: begin
          if (accept) begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CSUM_EN
            csum_q     <= csum_q + in_byte;
`endif
            // Fourth byte completes the word; present it to the RAM next cycle
            if (byte_cnt_q == 2'd3) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              wr_data_q  <= shift_d;
              wr_addr_q  <= 32'({word_cnt_q[ADDR_W-1:0], 2'b00});
            end
          end
        end
        WRITE: begin
          wr_en_q    <= 1'b0;
          word_cnt_q <= word_cnt_d;
          if (word_cnt_d == len_q) begin
`ifdef INST_LOADER_CSUM_EN
            state_q    <= CSUM;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q    <= RECV;
            in_ready_q <= 1'b1;
          end
        end
`ifdef INST_LOADER_CSUM_EN
        CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_byte == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= IDLE;
              err_q      <= 1'b1;
              done_q     <= 1'b0;
              cpu_hold_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected RAM writes are queued as each
// word is issued and a negedge monitor pops and compares every wr_en.
module tb_inst_loader;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len_words = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every RAM write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e[63:32]);
        check("wr_data", wr_data, mon_e[31:0]);
        check("in_ready_in_write", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    start = 1'b1;
    len_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_handshake: in_ready stayed 0, expected 1 (byte %h)", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gap);
    exp_q.push_back({32'(idx * 4), w});
    for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8], gap);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_end_timeout: done/err stayed 0, expected 1 within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle for 10 cycles
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_status", 32'({cpu_hold, done, in_ready, wr_en, busy, err}), 32'b100000);
    end
    check("idle_wr_addr", wr_addr, 32'h0);
    check("idle_wr_data", wr_data, 32'h0);

    // Single word, in_valid held high
    tick();
    do_start(6'd1);
    check("recv_in_ready", 32'({in_ready, busy}), 32'b11);
    send_word(32'h00002820, 0, 1'b0);
    @(negedge clk);
    check("single_wr_en_latency", 32'(wr_en), 32'd1);
`ifdef INST_LOADER_CSUM_EN
    send_byte(8'h48, 1'b0);
`else
    @(negedge clk);
`endif
    check("single_done", 32'({done, cpu_hold, busy, err}), 32'b1000);

    // Three words, gapped stream
    tick();
    do_start(6'd3);
    send_word(32'h8CB10000, 0, 1'b1);
    send_word(32'h8CB20004, 1, 1'b1);
    send_word(32'h02329822, 2, 1'b1);
`ifdef INST_LOADER_CSUM_EN
    send_byte(8'h6D, 1'b1);
`endif
    wait_end();
    check("three_done", 32'({done, cpu_hold, busy, err}), 32'b1000);
    check("three_queue_empty", 32'(exp_q.size()), 32'd0);

    // Bounds: oversize length rejected, then zero length completes at once
    tick();
    do_start(6'd33);
    repeat (3) @(negedge clk);
    check("oversize_status", 32'({done, cpu_hold, busy, err}), 32'b0101);
    check("oversize_in_ready", 32'(in_ready), 32'd0);
    tick();
    do_start(6'd0);
    @(negedge clk);
    check("zero_len_status", 32'({done, cpu_hold, busy, err}), 32'b1000);
    repeat (2) @(negedge clk);
    check("zero_len_idle_ready", 32'(in_ready), 32'd0);

    // Reset mid-load after two bytes of the second word
    tick();
    do_start(6'd2);
    send_word(32'h11223344, 0, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_status", 32'({in_ready, wr_en, busy, done, err, cpu_hold}), 32'b000001);
    check("midreset_wr_addr", wr_addr, 32'h0);
    check("midreset_wr_data", wr_data, 32'h0);
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(6'd1);
    send_word(32'hDEADBEEF, 0, 1'b0);
`ifdef INST_LOADER_CSUM_EN
    send_byte(8'h38, 1'b0);
`endif
    wait_end();
    check("after_reset_done", 32'({done, cpu_hold, busy, err}), 32'b1000);

`ifdef INST_LOADER_CSUM_EN
    // Good checksum then bad checksum
    tick();
    do_start(6'd1);
    send_word(32'h00002820, 0, 1'b0);
    send_byte(8'h48, 1'b0);
    check("csum_good", 32'({done, cpu_hold, busy, err}), 32'b1000);
    tick();
    do_start(6'd1);
    send_word(32'h00002820, 0, 1'b0);
    send_byte(8'h47, 1'b0);
    check("csum_bad", 32'({done, cpu_hold, busy, err}), 32'b0101);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
